// File: rtl/prop_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// prop_arbiter_pkg
// Shared types for the Propagate_literal arbiter:
//   formula_t        - formula operand/result word
//   lit_t            - literal {num, val}
//   prop_arb_state_t - arbiter FSM states
//   prop_rsp_t       - latched engine result {f, empty_clause, empty_formula}
// The optional watchdog is enabled by defining PROP_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package prop_arbiter_pkg;

    localparam int FORMULA_W = 16;
    localparam int LIT_NUM_W = 4;

    typedef logic [FORMULA_W-1:0] formula_t;

    typedef struct packed {
        logic [LIT_NUM_W-1:0] num;
        logic                 val;
    } lit_t;

    localparam formula_t ZERO_FORMULA = '0;
    localparam lit_t     ZERO_LIT     = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } prop_arb_state_t;

    typedef struct packed {
        formula_t f;
        logic     empty_clause;
        logic     empty_formula;
    } prop_rsp_t;

    localparam prop_rsp_t ZERO_RSP = '{f: ZERO_FORMULA, empty_clause: 1'b0, empty_formula: 1'b0};

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prop_arbiter_if.sv
// -----------------------------------------------------------------------------
// prop_arbiter_if
// Bundles the requester side and the engine side of the arbiter.
//   Requester side: req_valid/req_formula/req_lit in, req_ready/rsp_* out.
//   Engine side   : eng_find/eng_in_* out, eng_ended/eng_empty_*/eng_out_formula in.
//   busy          : arbiter has a job in flight.
//   rsp_timeout   : only when PROP_ARB_TIMEOUT_EN is defined.
// Handshake: a requester raises req_valid with stable operands and holds it
// until it sees its one-cycle req_ready pulse (operands captured on that edge),
// then drops req_valid the next cycle and waits for its one-cycle rsp_valid
// pulse; rsp_formula/rsp_empty_* are meaningful while rsp_valid is high.
// The engine gets a one-cycle eng_find pulse and answers with a one-cycle
// eng_ended pulse carrying its results.
// modport slave  : the arbiter.
// modport master : whatever drives the arbiter (requesters + engine).
// -----------------------------------------------------------------------------
interface prop_arbiter_if
    import prop_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic     [NUM_REQ-1:0] req_valid;
    formula_t [NUM_REQ-1:0] req_formula;
    lit_t     [NUM_REQ-1:0] req_lit;
    logic     [NUM_REQ-1:0] req_ready;
    logic     [NUM_REQ-1:0] rsp_valid;
    formula_t               rsp_formula;
    logic                   rsp_empty_clause;
    logic                   rsp_empty_formula;
    logic                   busy;
    logic                   eng_find;
    formula_t               eng_in_formula;
    lit_t                   eng_in_lit;
    logic                   eng_ended;
    logic                   eng_empty_clause;
    logic                   eng_empty_formula;
    formula_t               eng_out_formula;
`ifdef PROP_ARB_TIMEOUT_EN
    logic                   rsp_timeout;
`endif

    modport slave (
        input  req_valid, req_formula, req_lit,
        input  eng_ended, eng_empty_clause, eng_empty_formula, eng_out_formula,
        output req_ready, rsp_valid, rsp_formula, rsp_empty_clause, rsp_empty_formula,
        output busy, eng_find, eng_in_formula, eng_in_lit
`ifdef PROP_ARB_TIMEOUT_EN
        , output rsp_timeout
`endif
    );

    modport master (
        output req_valid, req_formula, req_lit,
        output eng_ended, eng_empty_clause, eng_empty_formula, eng_out_formula,
        input  req_ready, rsp_valid, rsp_formula, rsp_empty_clause, rsp_empty_formula,
        input  busy, eng_find, eng_in_formula, eng_in_lit
`ifdef PROP_ARB_TIMEOUT_EN
        , input rsp_timeout
`endif
    );

endinterface

// File: rtl/prop_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// prop_arbiter_rr_picker
// Combinational round-robin pick: the first set bit of req_i at or after
// ptr_i, wrapping around.
//   req_i   in  NUM_REQ   request vector
//   ptr_i   in  IDX_W     highest-priority index
//   grant_o out NUM_REQ   one-hot winner (zero when nothing requests)
//   idx_o   out IDX_W     winner index
//   any_o   out 1         some request is set
// -----------------------------------------------------------------------------
module prop_arbiter_rr_picker
    import prop_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        // Walk ptr, ptr+1, ... with wrap; the first hit wins.
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prop_arbiter.sv
// -----------------------------------------------------------------------------
// prop_arbiter
// Shares one Propagate_literal engine between NUM_REQ requesters. Round-robin
// grant, one job in flight: operands are latched at grant, the engine is
// started with a one-cycle eng_find, its result is latched on eng_ended and
// returned to the owner with a one-cycle rsp_valid.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high
//   bus         slave modport of prop_arbiter_if (requesters + engine)
//   dbg_state_o out  current FSM state
// Parameters:
//   NUM_REQ         number of requesters (>=2)
//   TIMEOUT_CYCLES  watchdog limit in WAIT (exists only with PROP_ARB_TIMEOUT_EN)
// Build option PROP_ARB_TIMEOUT_EN: a WAIT that lasts TIMEOUT_CYCLES without
// eng_ended is answered with empty_clause=1, the input formula echoed, and
// rsp_timeout=1 alongside rsp_valid.
// -----------------------------------------------------------------------------
module prop_arbiter
    import prop_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
`ifdef PROP_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic            clock,
    input  logic            reset,
    prop_arbiter_if.slave   bus,
    output prop_arb_state_t dbg_state_o
);

    localparam int IDX_W = clog2_min1(NUM_REQ);

    prop_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    formula_t           formula_q, formula_d;
    lit_t               lit_q, lit_d;
    prop_rsp_t          rsp_q, rsp_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               eng_find_q, eng_find_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef PROP_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    prop_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            formula_q   <= ZERO_FORMULA;
            lit_q       <= ZERO_LIT;
            rsp_q       <= ZERO_RSP;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            eng_find_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            formula_q   <= formula_d;
            lit_q       <= lit_d;
            rsp_q       <= rsp_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            eng_find_q  <= eng_find_d;
        end
    end

`ifdef PROP_ARB_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            timed_out_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timed_out_q   <= timed_out_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        formula_d   = formula_q;
        lit_d       = lit_q;
        rsp_d       = rsp_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        eng_find_d  = 1'b0;
`ifdef PROP_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timed_out_d   = timed_out_q;
        rsp_timeout_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d     = pick_idx;
                    formula_d   = bus.req_formula[pick_idx];
                    lit_d       = bus.req_lit[pick_idx];
                    req_ready_d = pick_grant;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                eng_find_d = 1'b1;
                state_d    = WAIT;
`ifdef PROP_ARB_TIMEOUT_EN
                cnt_d       = '0;
                timed_out_d = 1'b0;
`endif
            end

            WAIT: begin
                if (bus.eng_ended) begin
                    rsp_d.f             = bus.eng_out_formula;
                    rsp_d.empty_clause  = bus.eng_empty_clause;
                    rsp_d.empty_formula = bus.eng_empty_formula;
                    state_d             = RESPOND;
                end
`ifdef PROP_ARB_TIMEOUT_EN
                // Watchdog expiry reports a conflict and echoes the input.
                else if (cnt_q == CNT_LAST) begin
                    rsp_d.f             = formula_q;
                    rsp_d.empty_clause  = 1'b1;
                    rsp_d.empty_formula = 1'b0;
                    timed_out_d         = 1'b1;
                    state_d             = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            RESPOND: begin
                rsp_valid_d[owner_q] = 1'b1;
                // The owner just served drops to lowest priority.
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
`ifdef PROP_ARB_TIMEOUT_EN
                rsp_timeout_d = timed_out_q;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_formula       = rsp_q.f;
    assign bus.rsp_empty_clause  = rsp_q.empty_clause;
    assign bus.rsp_empty_formula = rsp_q.empty_formula;
    assign bus.busy              = (state_q != IDLE);
    assign bus.eng_find          = eng_find_q;
    assign bus.eng_in_formula    = formula_q;
    assign bus.eng_in_lit        = lit_q;
`ifdef PROP_ARB_TIMEOUT_EN
    assign bus.rsp_timeout       = rsp_timeout_q;
`endif
    assign dbg_state_o           = state_q;

endmodule
